// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state data memory: funct3 load/store sizes,
// controller states and wait counter width.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte mask, replicated store data,
// load extract/extend and request error. MISALIGN_CHECK_EN adds alignment errors.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_mask_c,
  output logic [31:0] store_data_c,
  output logic [31:0] load_data_c,
  output logic        err_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  mask;
  logic [31:0] load;
  logic        illegal;
  logic        misalign_c;

  assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

`ifdef MISALIGN_CHECK_EN
  assign misalign_c = ((size[1:0] == 2'b01) && addr_lo[0]) ||
                      ((size[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Lane decode; stores replicate data so the mask alone picks the lanes
  always_comb begin
    mask         = 4'b0000;
    load         = 32'h0;
    illegal      = 1'b0;
    store_data_c = 32'h0;
    case (size)
      F3_B, F3_BU: begin
        mask         = 4'(4'b0001 << addr_lo);
        store_data_c = {4{wdata[7:0]}};
        load         = (size == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      F3_H, F3_HU: begin
        mask         = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data_c = {2{wdata[15:0]}};
        load         = (size == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
      F3_W: begin
        mask         = 4'b1111;
        store_data_c = wdata;
        load         = rword;
      end
      default: illegal = 1'b1;
    endcase
    if (write && size[2]) illegal = 1'b1;
    err_c       = illegal || misalign_c;
    byte_mask_c = err_c ? 4'b0000 : mask;
    load_data_c = err_c ? 32'h0 : load;
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Byte-addressed data RAM behind a valid/ready port with WAIT_STATES latency and a
// one-cycle response pulse. Define MISALIGN_CHECK_EN to reject misaligned accesses.
module dmem_wait_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e                state, state_nx;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nx;
  logic                  accept_c, commit_c;

  logic                  cap_write;
  logic [2:0]            cap_size;
  logic [1:0]            cap_lo;
  logic [IDX_W-1:0]      cap_idx;
  logic [31:0]           cap_wdata;

  logic                  op_write;
  logic [2:0]            op_size;
  logic [1:0]            op_lo;
  logic [IDX_W-1:0]      op_idx;
  logic [31:0]           op_wdata;

  logic [3:0]            byte_mask_c;
  logic [31:0]           store_data_c, load_data_c, rword_c;
  logic                  err_c;

  logic [31:0]           mem [DEPTH_WORDS];

  assign req_ready = (state == ST_IDLE) && !reset;

  // Upper address bits alias by design
  if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_c;
    assign unused_addr_c = ^req_addr[ADDR_WIDTH-1:IDX_W+2];
  end

  // Zero-wait commits happen on the accept edge, before capture is loaded
  always_comb begin
    if (state == ST_IDLE) begin
      op_write = req_write;
      op_size  = req_size;
      op_lo    = req_addr[1:0];
      op_idx   = req_addr[IDX_W+1:2];
      op_wdata = req_wdata;
    end else begin
      op_write = cap_write;
      op_size  = cap_size;
      op_lo    = cap_lo;
      op_idx   = cap_idx;
      op_wdata = cap_wdata;
    end
  end

  assign rword_c = mem[op_idx];

  mem_lane_align u_lane (
    .size         (op_size),
    .write        (op_write),
    .addr_lo      (op_lo),
    .wdata        (op_wdata),
    .rword        (rword_c),
    .byte_mask_c  (byte_mask_c),
    .store_data_c (store_data_c),
    .load_data_c  (load_data_c),
    .err_c        (err_c)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_c = 1'b1;
          cnt_nx   = WAIT_CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_nx = ST_RESP;
            commit_c = 1'b1;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - WAIT_CNT_W'(1);
        if (cnt == WAIT_CNT_W'(1)) begin
          state_nx = ST_RESP;
          commit_c = !reset;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      cap_write  <= 1'b0;
      cap_size   <= 3'b000;
      cap_lo     <= 2'b00;
      cap_idx    <= '0;
      cap_wdata  <= 32'h0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      resp_valid <= commit_c;
      if (accept_c) begin
        cap_write <= req_write;
        cap_size  <= req_size;
        cap_lo    <= req_addr[1:0];
        cap_idx   <= req_addr[IDX_W+1:2];
        cap_wdata <= req_wdata;
      end
      if (commit_c) begin
        resp_err   <= err_c;
        resp_rdata <= op_write ? 32'h0 : load_data_c;
      end
    end
  end

  // Data array has no reset; a masked-off store leaves the word intact
  always_ff @(posedge clk) begin
    if (commit_c && op_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask_c[b]) mem[op_idx][8*b +: 8] <= store_data_c[8*b +: 8];
      end
    end
  end

endmodule
